// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full and level tracking for the async FIFO.
// Read Gray pointer crosses in via a two-flop synchroniser.
module fifo_wptr_full #(
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = 6,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  input  logic          wr_rq,
  input  logic [AW:0]   rptr_gray,
  input  logic          ovf_clr,
  output logic          wr_en,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   wptr_gray,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wr_level,
  output logic          overflow
);

  logic [AW:0] wbin;
  logic [AW:0] wbin_nxt;
  logic [AW:0] wgray_nxt;
  logic [AW:0] rq1;
  logic [AW:0] rq2;
  logic [AW:0] rbin_s;
  logic [AW:0] full_cmp;
  logic        full_nxt;
  logic        ovf_nxt;

  assign wr_en     = wr_rq & ~full;
  assign wbin_nxt  = wbin + {{AW{1'b0}}, wr_en};
  assign wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);
  assign waddr     = wbin[AW-1:0];

  // Full when the next write pointer is exactly one lap ahead
  assign full_cmp = {~rq2[AW:AW-1], rq2[AW-2:0]};
  assign full_nxt = (wgray_nxt == full_cmp);
  assign ovf_nxt  = (wr_rq & full) | (overflow & ~ovf_clr);

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= AW; i++) begin
      rbin_s[i] = ^(rq2 >> i);
    end
  end

  assign wr_level    = wbin - rbin_s;
  assign almost_full = (wr_level >= (AW+1)'(AF_LEVEL));

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= rptr_gray;
      rq2 <= rq1;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wbin      <= '0;
      wptr_gray <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wbin      <= wbin_nxt;
      wptr_gray <= wgray_nxt;
      full      <= full_nxt;
      overflow  <= ovf_nxt;
    end
  end

endmodule
